// File: rtl/conv_result_streamer.sv
// conv_result_streamer: waits SETTLE cycles after start, snapshots N_OUT convolver results, streams them out over valid/ready
// Ports: clk, rstn (async active-low); start pulse; conv_in flattened results (word k at [k*W +: W]);
//        out_data/out_valid/out_ready/out_last word stream; busy (not idle); done (pulse after last transfer)
module conv_result_streamer #(
  parameter int N_OUT = 15,
  parameter int W = 16,
  parameter int SETTLE = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [N_OUT*W-1:0] conv_in,
  output logic [W-1:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, STREAM = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, nxt;
  logic [W-1:0] mem [N_OUT];
  assign nxt = idx + 1'b1;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      done <= 1'b0;
      for (int k = 0; k < N_OUT; k++) mem[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SETTLE - 1)) begin
            // word 0 goes straight to the output register so it is valid on the next cycle
            for (int k = 0; k < N_OUT; k++) mem[k] <= conv_in[k*W +: W];
            idx <= '0;
            out_data <= conv_in[W-1:0];
            out_valid <= 1'b1;
            out_last <= N_OUT == 1;
            state <= STREAM;
          end
        end
        STREAM: if (out_ready) begin
          if (idx == IW'(N_OUT - 1)) begin
            state <= IDLE;
            idx <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            done <= 1'b1;
          end else begin
            idx <= nxt;
            out_data <= mem[nxt];
            out_last <= nxt == IW'(N_OUT - 1);
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_conv_result_streamer.sv
// tb_conv_result_streamer: queue-model checked bench for conv_result_streamer
module tb_conv_result_streamer;
  localparam int N = 15, W = 16, S = 64;
  logic clk = 0, rstn = 0, start = 0, out_ready = 0;
  logic [N*W-1:0] conv_in = '0;
  logic [W-1:0] out_data;
  logic out_valid, out_last, busy, done;
  int passed = 0, total = 0, dcount = 0, rdy_mode = 0, pi = 0, n = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] exp2 [N] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
                             16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  logic [W-1:0] rx [$];
  int m_mode = 0, m_left = 0;
  logic [W-1:0] m_q [$];
  logic [W-1:0] m_data = '0;
  logic m_done = 0;

  conv_result_streamer #(.N_OUT(N), .W(W), .SETTLE(S)) dut (
    .clk(clk), .rstn(rstn), .start(start), .conv_in(conv_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // model: idle / counting down / a queue of words still to deliver
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; m_left = 0; m_q.delete(); m_data = '0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_mode == 0) begin
        if (start) begin m_mode = 1; m_left = S; end
      end else if (m_mode == 1) begin
        if (m_left == 1) begin
          for (int k = 0; k < N; k++) m_q.push_back(conv_in[k*W +: W]);
          m_data = m_q[0];
          m_mode = 2;
        end else m_left--;
      end else if (out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin m_mode = 0; m_done = 1; end
        else m_data = m_q[0];
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", 32'(out_valid), 32'(m_mode == 2));
    chk("data", 32'(out_data), 32'(m_data));
    chk("last", 32'(out_last), 32'(m_mode == 2 && m_q.size() == 1));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("done", 32'(done), 32'(m_done));
    if (out_valid && out_ready) rx.push_back(out_data);
    if (done) dcount++;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode != 0) begin out_ready = pat[pi % 4]; pi++; end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_valid(input int inj, output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(posedge clk); #1; cnt++;
      start = inj != 0 && cnt == inj;
    end
    start = 0;
    chk("valid reached", 32'(out_valid), 1);
  endtask

  task automatic wait_done(input int inj, output int cnt);
    cnt = 0;
    while (!done && cnt < 400) begin
      @(posedge clk); #1; cnt++;
      start = inj != 0 && cnt == inj;
    end
    start = 0;
    chk("done reached", 32'(done), 1);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (5) @(posedge clk);
    #1 rstn = 1;
    repeat (100) @(posedge clk);
    #1;
    chk("t1 valid", 32'(out_valid), 0);
    chk("t1 busy", 32'(busy), 0);
    chk("t1 done", 32'(done), 0);
    chk("t1 last", 32'(out_last), 0);
    chk("t1 data", 32'(out_data), 0);

    for (int k = 0; k < N; k++) conv_in[k*W +: W] = exp2[k];
    out_ready = 1; rx.delete(); dcount = 0;
    pulse_start();
    chk("t2 busy rise", 32'(busy), 1);
    wait_valid(0, n);
    chk("t2 latency", n, 64);
    wait_done(0, n);
    chk("t2 stream len", n, 15);
    chk("t2 busy fall", 32'(busy), 0);
    settle();
    chk("t2 count", rx.size(), 15);
    for (int k = 0; k < N && k < rx.size(); k++) chk("t2 word", 32'(rx[k]), 32'(exp2[k]));
    chk("t2 done pulses", dcount, 1);

    for (int k = 0; k < N; k++) conv_in[k*W +: W] = W'(k * 16'h0101);
    rx.delete(); pi = 0; rdy_mode = 1;
    pulse_start();
    wait_valid(0, n);
    wait_done(0, n);
    settle();
    rdy_mode = 0; out_ready = 1;
    chk("t3 count", rx.size(), 15);
    for (int k = 0; k < N && k < rx.size(); k++) chk("t3 word", 32'(rx[k]), k * 32'h0101);

    for (int k = 0; k < N; k++) conv_in[k*W +: W] = W'(k * 16'h1111 + 3);
    rx.delete();
    pulse_start();
    wait_valid(0, n);
    conv_in = '1;
    wait_done(0, n);
    settle();
    chk("t4 count", rx.size(), 15);
    for (int k = 0; k < N && k < rx.size(); k++) chk("t4 word", 32'(rx[k]), k * 32'h1111 + 3);

    for (int k = 0; k < N; k++) conv_in[k*W +: W] = W'(16'h0100 + k);
    rx.delete(); dcount = 0;
    pulse_start();
    wait_valid(10, n);
    chk("t5 latency ignored start", n, 64);
    wait_done(5, n);
    chk("t5 stream len", n, 15);
    start = 1;
    @(posedge clk); #1 start = 0;
    chk("t5 restart busy", 32'(busy), 1);
    wait_valid(0, n);
    chk("t5 back-to-back latency", n, 64);
    wait_done(0, n);
    settle();
    chk("t5 done pulses", dcount, 2);
    chk("t5 count", rx.size(), 30);
    for (int k = 0; k < 30 && k < rx.size(); k++) chk("t5 word", 32'(rx[k]), 32'h0100 + k % 15);

    for (int k = 0; k < N; k++) conv_in[k*W +: W] = W'(16'hA000 + 3 * k);
    pulse_start();
    wait_valid(0, n);
    repeat (5) @(posedge clk);
    #1;
    chk("t6 word5", 32'(out_data), 32'hA00F);
    #2 rstn = 0;
    #1;
    chk("t6 rst valid", 32'(out_valid), 0);
    chk("t6 rst busy", 32'(busy), 0);
    chk("t6 rst data", 32'(out_data), 0);
    chk("t6 rst last", 32'(out_last), 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    chk("t6 idle after release", 32'(busy), 0);
    rx.delete(); dcount = 0;
    pulse_start();
    wait_valid(0, n);
    chk("t6 latency", n, 64);
    wait_done(0, n);
    settle();
    chk("t6 count", rx.size(), 15);
    if (rx.size() == 15) begin
      chk("t6 first", 32'(rx[0]), 32'hA000);
      chk("t6 final", 32'(rx[14]), 32'hA02A);
    end
    chk("t6 done pulses", dcount, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Downstream stage of the 8x8-tap linear convolver. Takes its 15 parallel 16-bit results and turns them into a valid/ready word stream.
- A start pulse marks new S/H operands being applied to the convolver. The block then waits a fixed settle time while the convolver's counters sweep all 64 products.
- After the wait it snapshots all 15 results and emits them in order, index 0 first, with backpressure support.

Parameters:
- N_OUT, 15, number of result words per convolution (2*8-1).
- W, 16, width of each result word.
- SETTLE, 64, clock cycles from accepted start to snapshot. Equals the convolver's product-sweep length. Must be >= 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: new operands applied to the convolver. Honoured only in IDLE.
- conv_in  in  N_OUT*W  flattened convolver results. Word k is bits [k*W+W-1 : k*W].
- out_data  out  W  current streamed word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when high together with out_valid.
- out_last  out  1  high with out_valid on word N_OUT-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last word transfers.

Behaviour:
- States: IDLE, WAIT, STREAM. State register, counters and buffer all reset asynchronously on rstn=0.
- Reset values:
  - state=IDLE, wait counter=0, index=0, buffer all zeros.
  - out_data=0, out_valid=0, out_last=0, busy=0, done=0.
- IDLE:
  - start=1 at a clock edge moves to WAIT and clears the wait counter.
  - Otherwise the block stays in IDLE.
- WAIT:
  - The counter increments every cycle.
  - At the edge where counter==SETTLE-1: latch all of conv_in into an N_OUT x W buffer, set index=0, enter STREAM.
  - First out_valid appears SETTLE edges after the edge that sampled start (edge 64 by default).
- STREAM:
  - out_valid=1 and out_data=buffer[index], both registered.
  - out_last=(index==N_OUT-1).
  - A transfer occurs on an edge with out_valid & out_ready. On a transfer, index increments.
  - Transfer with index==N_OUT-1: next state IDLE; out_valid, out_last and index go to 0; done=1 for exactly one cycle.
  - With out_ready=0, out_data, out_valid and out_last hold unchanged indefinitely. There is no timeout.
  - out_valid never drops before its word has transferred.
- Data integrity: conv_in changes after the snapshot do not affect streamed words. The buffer is rewritten only at the next snapshot.
- start in WAIT or STREAM is ignored. It is not queued and does not restart the counter.
- start in the same cycle that done is asserted (state already IDLE) is accepted. This gives back-to-back operation with one idle cycle minimum.
- out_data in IDLE holds the last streamed word. Consumers must qualify data with out_valid.
- Throughput: with out_ready held high, one word per cycle. 15 consecutive valid cycles, out_last on the 15th.
- Reset asserted mid-WAIT or mid-STREAM: immediate return to reset values. No done pulse and no further words. A partially streamed result is discarded.
- No arithmetic is performed. Words pass through bit-exact at W bits.

Test Plan:
1. Reset/idle: hold rstn=0, then release with no start for 100 cycles -> out_valid, busy, done, out_last stay 0 and out_data=0.
2. Basic stream:
   - Stimulus: conv_in = all-ones S/H results {1,2,3,4,5,6,7,8,7,6,5,4,3,2,1}, start pulse, out_ready=1.
   - Response: busy rises the cycle after start. First out_valid exactly 64 edges after the start edge. Words 1..8..1 on 15 consecutive cycles, out_last only on the final 1, done pulse once, busy falls with done.
3. Backpressure:
   - Stimulus: conv_in words k*0x0101 (k=0..14). Toggle out_ready 1,0,0,1 repeating.
   - Response: each word is held stable while out_ready=0. Sequence 0x0000..0x0E0E is delivered with no loss or duplication.
4. Snapshot isolation: change conv_in to 0xFFFF in all words one cycle after the snapshot -> streamed words still equal the pre-snapshot values.
5. Ignored start: pulse start at cycle 10 of WAIT and again mid-STREAM -> timing and word count are unchanged and exactly one done pulse occurs. A start in the done cycle begins a new WAIT whose first valid appears 64 edges later.
6. Reset mid-operation:
   - Stimulus: assert rstn=0 asynchronously (between edges) during word 5 of STREAM.
   - Response: outputs clear immediately without waiting for a clock. After release, the block is IDLE. A fresh start streams the full 15 words from index 0.
